apb_bif_bridge: RTL and testbench
=================================

// Module: apb_bif_bridge
// PURPOSE
//  APB3 slave to bif-bus master bridge; sits directly upstream of an auto-generated register bank.
//  Converts each APB transfer into one single-cycle bif_wr_ev/bif_rd_ev pulse and waits for bif_rd_vld_ev.
//  Address-window check drives bif_sel. Unanswered reads time out and complete with PSLVERR.
// PARAMETERS
//  AWID       16       address width (paddr, bif_addr)
//  DWID       32       data width (pwdata, prdata, bif data)
//  BASE_ADDR  0        first byte address of the window
//  WIN_SIZE   'h100    window size in bytes; in_win = (paddr>=BASE_ADDR) && (paddr<BASE_ADDR+WIN_SIZE)
//  TIMEOUT    15       max RWAIT cycles without bif_rd_vld_ev, 1..255
//  ERR_EN     1        1: errors drive pslverr=1; 0: pslverr tied 0 (read data still 0)
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     async reset, active low
//  psel           in   1     APB select
//  penable        in   1     APB access phase
//  pwrite         in   1     1=write
//  paddr          in   AWID  APB address
//  pwdata         in   DWID  APB write data
//  prdata         out  DWID  read data, valid when pready=1
//  pready         out  1     transfer complete
//  pslverr        out  1     error, valid when pready=1
//  bif_addr       out  AWID  latched paddr, unmodified (bank decodes absolute addresses)
//  bif_sel        out  1     in_win of latched address
//  bif_wr_ev      out  1     write strobe, 1-cycle pulse
//  bif_rd_ev      out  1     read strobe, 1-cycle pulse
//  bif_wr_dat     out  DWID  latched pwdata
//  bif_rd_dat     in   DWID  read data from bank
//  bif_rd_vld_ev  in   1     read data valid, 1-cycle pulse
// BEHAVIOUR
//  Reset: every output 0, state IDLE, timeout counter 0. All outputs registered.
//  FSM IDLE -> ACC -> [RWAIT] -> RESP -> IDLE.
//  IDLE: on psel & !penable latch paddr, pwdata, pwrite, in_win; go ACC. Other inputs ignored.
//  ACC (1 cycle), chosen by latched values:
//   write       : bif_wr_ev=1 for one cycle, bif_sel=in_win -> RESP, no error (outside window: bif_sel=0, pslverr=ERR_EN)
//   read, in    : bif_rd_ev=1, bif_sel=1 -> RWAIT, clear counter
//   read, out   : no bif pulse; prdata=0, pslverr=ERR_EN -> RESP
//  RWAIT: on bif_rd_vld_ev capture bif_rd_dat into prdata, pslverr=0 -> RESP.
//   Otherwise increment counter; at counter==TIMEOUT set prdata=0, pslverr=ERR_EN -> RESP.
//   bif_rd_ev is never re-issued.
//  RESP: pready=1 for exactly one cycle -> IDLE. prdata/pslverr hold until the next ACC, then clear.
//  Latency at a zero-wait bank (bank vld arrives the cycle after rd_ev):
//   write: setup T0, bif_wr_ev T1, pready T2.
//   read : setup T0, bif_rd_ev T1, vld T2, pready T3.
//  bif_wr_ev and bif_rd_ev are mutually exclusive. At most one bif event per APB transfer.
//  Abort: psel=0 in ACC/RWAIT/RESP -> IDLE next cycle. No further bif pulses; pready stays 0.
//  Stray bif_rd_vld_ev outside RWAIT is ignored (late reply after abort or timeout).
//  vld on the same cycle the counter reaches TIMEOUT: vld wins, data captured, no error.
//  Back-to-back transfers: a new setup phase can be accepted the cycle after RESP.
//  Async reset mid-transfer: immediate return to reset values; the transfer is dropped.
//  Counter width: $clog2(TIMEOUT+1); it never wraps.
// TESTING
//  1. Write paddr=BASE+'h8, pwdata=32'hA5A5_0001 -> bif_wr_ev T1 with bif_sel=1, bif_addr=BASE+'h8; pready T2, pslverr=0.
//  2. Read BASE+'h8, bank returns vld T2 with 32'h1234_5678 -> pready T3, prdata=32'h1234_5678, pslverr=0.
//  3. Read in-window unmapped address, no vld -> pready after 1+TIMEOUT RWAIT cycles, prdata=0, pslverr=1. Late vld next cycle ignored.
//  4. Write BASE+WIN_SIZE -> no bif_wr_ev, bif_sel=0, pready T2, pslverr=1. Repeat with ERR_EN=0 -> pslverr=0.
//  5. rst_n low during RWAIT -> all outputs 0 immediately. Next read after release completes normally.
//  6. Write then read back-to-back plus psel drop in ACC -> correct pready count; exactly one bif event per completed transfer.

Source files
------------

// File: rtl/apb_bif_bridge.sv
// APB3 slave to bif-bus master bridge: one bif strobe per APB transfer, address-window
// check on bif_sel, and a bounded wait for read data that completes with an error on timeout.
module apb_bif_bridge #(
  parameter int unsigned AWID      = 16,
  parameter int unsigned DWID      = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WIN_SIZE  = 'h100,
  parameter int unsigned TIMEOUT   = 15,
  parameter bit          ERR_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AWID-1:0] paddr,
  input  logic [DWID-1:0] pwdata,
  output logic [DWID-1:0] prdata,
  output logic            pready,
  output logic            pslverr,
  output logic [AWID-1:0] bif_addr,
  output logic            bif_sel,
  output logic            bif_wr_ev,
  output logic            bif_rd_ev,
  output logic [DWID-1:0] bif_wr_dat,
  input  logic [DWID-1:0] bif_rd_dat,
  input  logic            bif_rd_vld_ev
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  localparam logic [AWID:0] WIN_LO  = (AWID+1)'(BASE_ADDR);
  localparam logic [AWID:0] WIN_SZ  = (AWID+1)'(WIN_SIZE);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACC, RWAIT, RESP} state_t;

  state_t          state, next_state;
  logic            lat_write, lat_win;
  logic [CW-1:0]   cnt;
  logic [AWID:0]   offset;
  logic            in_win_now, setup;
  logic            wr_ev_d, rd_ev_d, pready_d, pslverr_d;
  logic [DWID-1:0] prdata_d;

  // Offset from the window base; the extra MSB is the borrow when paddr < BASE_ADDR.
  assign offset     = {1'b0, paddr} - WIN_LO;
  assign in_win_now = !offset[AWID] && (offset < WIN_SZ);
  assign setup      = psel && !penable;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (setup) next_state = ACC;
      ACC: begin
        if (!psel)                      next_state = IDLE;
        else if (!lat_write && lat_win) next_state = RWAIT;
        else                            next_state = RESP;
      end
      RWAIT: begin
        if (!psel)                                   next_state = IDLE;
        else if (bif_rd_vld_ev || (cnt == CNT_MAX))  next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Register inputs for the outputs; vld has priority over a simultaneous timeout.
  always_comb begin
    wr_ev_d   = 1'b0;
    rd_ev_d   = 1'b0;
    pready_d  = 1'b0;
    prdata_d  = prdata;
    pslverr_d = pslverr;
    if (state == IDLE && next_state == ACC) begin
      wr_ev_d   = pwrite && in_win_now;
      rd_ev_d   = !pwrite && in_win_now;
      prdata_d  = '0;
      pslverr_d = 1'b0;
    end
    if (next_state == RESP) begin
      pready_d = 1'b1;
      if (state == RWAIT && bif_rd_vld_ev) begin
        prdata_d  = bif_rd_dat;
        pslverr_d = 1'b0;
      end else if (state == ACC && lat_write && lat_win) begin
        pslverr_d = 1'b0;
      end else begin
        prdata_d  = '0;
        pslverr_d = ERR_EN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      bif_addr   <= '0;
      bif_sel    <= 1'b0;
      bif_wr_ev  <= 1'b0;
      bif_rd_ev  <= 1'b0;
      bif_wr_dat <= '0;
      lat_write  <= 1'b0;
      lat_win    <= 1'b0;
      cnt        <= '0;
    end else begin
      prdata    <= prdata_d;
      pready    <= pready_d;
      pslverr   <= pslverr_d;
      bif_wr_ev <= wr_ev_d;
      bif_rd_ev <= rd_ev_d;
      if (state == IDLE && setup) begin
        bif_addr   <= paddr;
        bif_wr_dat <= pwdata;
        bif_sel    <= in_win_now;
        lat_write  <= pwrite;
        lat_win    <= in_win_now;
      end
      if (state == ACC)                                 cnt <= '0;
      else if (state == RWAIT && next_state == RWAIT)   cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_bif_bridge.sv
// Self-checking bench for apb_bif_bridge: scoreboard of expected APB responses popped
// on pready, plus bif strobe and pready counters sampled on the falling edge.
module tb_apb_bif_bridge;

  localparam int AWID = 16;
  localparam int DWID = 32;
  localparam int BASE = 0;
  localparam int WIN  = 'h100;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AWID-1:0] paddr = '0;
  logic [DWID-1:0] pwdata = '0;
  logic [DWID-1:0] bif_rd_dat = '0;
  logic            bif_rd_vld_ev = 1'b0;

  logic [DWID-1:0] prdata, bif_wr_dat, u1_prdata, u1_bif_wr_dat;
  logic            pready, pslverr, bif_sel, bif_wr_ev, bif_rd_ev;
  logic            u1_pready, u1_pslverr, u1_bif_sel, u1_bif_wr_ev, u1_bif_rd_ev;
  logic [AWID-1:0] bif_addr, u1_bif_addr;

  typedef struct {
    logic [DWID-1:0] prdata;
    logic            pslverr;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_seen = 0, rd_seen = 0, rdy_seen = 0;

  always #5 clk = ~clk;

  apb_bif_bridge #(.AWID(AWID), .DWID(DWID), .BASE_ADDR(BASE), .WIN_SIZE(WIN),
                   .TIMEOUT(TO), .ERR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .bif_addr(bif_addr), .bif_sel(bif_sel), .bif_wr_ev(bif_wr_ev), .bif_rd_ev(bif_rd_ev),
    .bif_wr_dat(bif_wr_dat), .bif_rd_dat(bif_rd_dat), .bif_rd_vld_ev(bif_rd_vld_ev)
  );

  apb_bif_bridge #(.AWID(AWID), .DWID(DWID), .BASE_ADDR(BASE), .WIN_SIZE(WIN),
                   .TIMEOUT(TO), .ERR_EN(1'b0)) u_noerr (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(u1_prdata), .pready(u1_pready),
    .pslverr(u1_pslverr), .bif_addr(u1_bif_addr), .bif_sel(u1_bif_sel),
    .bif_wr_ev(u1_bif_wr_ev), .bif_rd_ev(u1_bif_rd_ev), .bif_wr_dat(u1_bif_wr_dat),
    .bif_rd_dat(bif_rd_dat), .bif_rd_vld_ev(bif_rd_vld_ev)
  );

  always @(negedge clk) begin
    if (bif_wr_ev) wr_seen++;
    if (bif_rd_ev) rd_seen++;
    if (pready)    rdy_seen++;
  end

  // One APB transfer; vld_at = RWAIT cycle index for the bank reply, -1 for none.
  task automatic apb_txn(input logic wr, input logic [AWID-1:0] addr,
                         input logic [DWID-1:0] wdata, input int vld_at,
                         input logic [DWID-1:0] rdata, input string name);
    exp_t e;
    bit   win, done;
    int   wr0, rd0;
    win = (int'(addr) >= BASE) && (int'(addr) < BASE + WIN);
    e.prdata = '0; e.pslverr = 1'b1; e.lat = 0;
    if (wr) e.pslverr = !win;
    else if (win && vld_at >= 0 && vld_at <= TO) begin
      e.prdata = rdata; e.pslverr = 1'b0; e.lat = vld_at + 1;
    end else if (win) e.lat = TO + 1;
    sb.push_back(e);
    wr0 = wr_seen; rd0 = rd_seen;

    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    vectors++;
    if (bif_wr_ev !== (wr && win) || bif_rd_ev !== (!wr && win)) begin
      miscompares++;
      $display("FAIL %s acc_events wr/rd got %b%b exp %b%b", name, bif_wr_ev, bif_rd_ev,
               wr && win, !wr && win);
    end
    vectors++;
    if (bif_sel !== win || bif_addr !== addr) begin
      miscompares++;
      $display("FAIL %s acc_sel_addr got %b/%h exp %b/%h", name, bif_sel, bif_addr, win, addr);
    end
    if (wr) begin
      vectors++;
      if (bif_wr_dat !== wdata) begin
        miscompares++;
        $display("FAIL %s wr_dat got %h exp %h", name, bif_wr_dat, wdata);
      end
    end
    penable = 1'b1;

    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      bif_rd_vld_ev = 1'b0;
      if (pready) begin
        e = sb.pop_front();
        done = 1'b1;
        vectors++;
        if (prdata !== e.prdata || pslverr !== e.pslverr) begin
          miscompares++;
          $display("FAIL %s resp prdata/err got %h/%b exp %h/%b", name, prdata, pslverr,
                   e.prdata, e.pslverr);
        end
        vectors++;
        if (k != e.lat) begin
          miscompares++;
          $display("FAIL %s latency got %0d exp %0d", name, k, e.lat);
        end
        vectors++;
        if (u1_pready !== 1'b1 || u1_pslverr !== 1'b0) begin
          miscompares++;
          $display("FAIL %s noerr_inst rdy/err got %b/%b exp 1/0", name, u1_pready, u1_pslverr);
        end
      end else if (k == vld_at) begin
        bif_rd_vld_ev = 1'b1;
        bif_rd_dat    = rdata;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s pready_timeout got none exp within 40 cycles", name);
      void'(sb.pop_front());
    end
    psel = 1'b0; penable = 1'b0; bif_rd_vld_ev = 1'b0;
    vectors++;
    if (wr_seen - wr0 != int'(wr && win) || rd_seen - rd0 != int'(!wr && win)) begin
      miscompares++;
      $display("FAIL %s event_count wr/rd got %0d/%0d exp %0d/%0d", name, wr_seen - wr0,
               rd_seen - rd0, int'(wr && win), int'(!wr && win));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({prdata, pready, pslverr, bif_addr, bif_sel, bif_wr_ev, bif_rd_ev, bif_wr_dat} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got nonzero exp all zero");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (pready !== 1'b0 || bif_wr_ev !== 1'b0 || bif_rd_ev !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got rdy=%b wr=%b rd=%b exp 0", pready, bif_wr_ev, bif_rd_ev);
    end
  endtask

  task automatic test_write();
    apb_txn(1'b1, 16'(BASE + 'h8), 32'hA5A5_0001, -1, '0, "write_in");
  endtask

  task automatic test_read();
    apb_txn(1'b0, 16'(BASE + 'h8), '0, 0, 32'h1234_5678, "read_zero_wait");
    apb_txn(1'b0, 16'(BASE + 'h30), '0, 3, 32'hCAFE_0003, "read_wait3");
  endtask

  task automatic test_timeout();
    int rd0;
    apb_txn(1'b0, 16'(BASE + 'hFC), '0, -1, '0, "read_timeout");
    rd0 = rd_seen;
    @(negedge clk);
    bif_rd_vld_ev = 1'b1; bif_rd_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    bif_rd_vld_ev = 1'b0;
    vectors++;
    if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b1 || rd_seen != rd0) begin
      miscompares++;
      $display("FAIL late_vld got rdy=%b prdata=%h err=%b exp 0/0/1", pready, prdata, pslverr);
    end
    apb_txn(1'b0, 16'(BASE + 'h44), '0, TO, 32'h0BAD_F00D, "vld_at_timeout");
  endtask

  task automatic test_out_of_window();
    apb_txn(1'b1, 16'(BASE + WIN), 32'h1111_2222, -1, '0, "write_out");
    apb_txn(1'b0, 16'(BASE + WIN), '0, 0, 32'h5555_AAAA, "read_out");
    apb_txn(1'b0, 16'hFFFF, '0, -1, '0, "read_top");
    apb_txn(1'b1, 16'(BASE + WIN - 1), 32'h7777_0000, -1, '0, "write_last_in");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'(BASE + 'h20);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    vectors++;
    if (bif_sel !== 1'b1 || bif_addr !== 16'(BASE + 'h20)) begin
      miscompares++;
      $display("FAIL rwait_state got sel=%b addr=%h exp 1/%h", bif_sel, bif_addr, BASE + 'h20);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({prdata, pready, pslverr, bif_addr, bif_sel, bif_wr_ev, bif_rd_ev, bif_wr_dat} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got addr=%h sel=%b wr_dat=%h exp all zero", bif_addr, bif_sel,
               bif_wr_dat);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apb_txn(1'b0, 16'(BASE + 'h24), '0, 0, 32'h0000_2424, "read_after_reset");
  endtask

  task automatic test_back_to_back();
    int wr0, rd0, rdy0;
    wr0 = wr_seen; rd0 = rd_seen; rdy0 = rdy_seen;
    apb_txn(1'b1, 16'(BASE + 'h40), 32'h4040_4040, -1, '0, "b2b_write");
    apb_txn(1'b0, 16'(BASE + 'h40), '0, 0, 32'h4040_4040, "b2b_read");
    // Abort in ACC: the strobe already issued, then nothing further.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'(BASE + 'h50);
    @(negedge clk);
    vectors++;
    if (bif_rd_ev !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_acc_strobe got %b exp 1", bif_rd_ev);
    end
    psel = 1'b0;
    @(negedge clk);
    bif_rd_vld_ev = 1'b1; bif_rd_dat = 32'h5050_5050;
    @(negedge clk);
    bif_rd_vld_ev = 1'b0;
    repeat (3) @(negedge clk);
    apb_txn(1'b1, 16'(BASE + 'h60), 32'h6060_6060, -1, '0, "b2b_after_abort");
    vectors++;
    if (rdy_seen - rdy0 != 3 || wr_seen - wr0 != 2 || rd_seen - rd0 != 2) begin
      miscompares++;
      $display("FAIL b2b_counts rdy/wr/rd got %0d/%0d/%0d exp 3/2/2", rdy_seen - rdy0,
               wr_seen - wr0, rd_seen - rd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish exp finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_out_of_window();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
